// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// MemOp encodings follow the RISC-V funct3 field.
package lsu_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  // 1 when the op is legal for the direction and the address is aligned
  function automatic logic access_ok(
    input logic       wr,
    input logic [2:0] op,
    input logic [1:0] lo
  );
    logic ok;
    case (op)
      MOP_B:   ok = 1'b1;
      MOP_H:   ok = ~lo[0];
      MOP_W:   ok = (lo == 2'b00);
      MOP_BU:  ok = ~wr;
      MOP_HU:  ok = ~wr & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store mask/data replication and
// load extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  assign shifted = rword >> {addr_lo, 3'b000};

  always_comb begin
    wmask    = 4'b0000;
    wdata_al = '0;
    case (op)
      MOP_B: begin
        wmask    = 4'b0001 << addr_lo;
        wdata_al = {4{wdata[7:0]}};
      end
      MOP_H: begin
        wmask    = 4'b0011 << addr_lo;
        wdata_al = {2{wdata[15:0]}};
      end
      MOP_W: begin
        wmask    = 4'b1111;
        wdata_al = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (op)
      MOP_B:   rdata = {{24{shifted[7]}}, shifted[7:0]};
      MOP_H:   rdata = {{16{shifted[15]}}, shifted[15:0]};
      MOP_W:   rdata = shifted;
      MOP_BU:  rdata = {24'h0, shifted[7:0]};
      MOP_HU:  rdata = {16'h0, shifted[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one handshaked transaction at a time
// between the execute stage and the data memory bus.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [3:0]        mem_req_wmask,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  lsu_state_t state;
  logic       wr_q;
  logic [2:0] op_q;
  logic [1:0] lo_q;

  logic [2:0]  al_op;
  logic [1:0]  al_lo;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        ok;

  // Store path uses the live request, load path the latched one
  assign al_op = (state == S_IDLE) ? req_op : op_q;
  assign al_lo = (state == S_IDLE) ? req_addr[1:0] : lo_q;
  assign ok    = access_ok(req_wr, req_op, req_addr[1:0]);

  lsu_align u_align (
    .op       (al_op),
    .addr_lo  (al_lo),
    .wdata    (req_wdata),
    .rword    (mem_rsp_rdata),
    .wmask    (al_wmask),
    .wdata_al (al_wdata),
    .rdata    (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_q          <= 1'b0;
      op_q          <= 3'b000;
      lo_q          <= 2'b00;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wmask <= 4'b0000;
      mem_req_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q      <= req_wr;
            op_q      <= req_op;
            lo_q      <= req_addr[1:0];
            req_ready <= 1'b0;
            if (!ok) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= S_RESP;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_req_wen   <= req_wr;
              mem_req_wmask <= req_wr ? al_wmask : 4'b0000;
              mem_req_wdata <= req_wr ? al_wdata : '0;
              state         <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            resp_valid <= 1'b1;
            resp_err   <= mem_rsp_err;
            resp_rdata <= (mem_rsp_err || wr_q) ? '0 : al_rdata;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for the load/store unit.
// Each task drives one scenario and checks its own results.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        mem_rsp_err = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] r_rdata, r_addr, r_wdata;
  logic        r_err, r_wen, r_unstable;
  logic [3:0]  r_mask;
  int          r_lat, r_nreq;

  always #5 clk = ~clk;

  lsu dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wr        (req_wr),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wmask (mem_req_wmask),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  // One request through a simple bus model with optional stalls.
  task automatic run(
    input logic        wr,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rword,
    input logic        rerr,
    input int          req_stall,
    input int          resp_stall
  );
    int cyc, rs, ps;
    logic got, pend, seen_req, seen_rsp;
    r_rdata = '0; r_err = 1'b0; r_addr = '0;
    r_wdata = '0; r_wen = 1'b0; r_mask = '0;
    r_lat = -1; r_nreq = 0; r_unstable = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_op = op;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; rs = 0; ps = 0;
    got = 1'b0; pend = 1'b0;
    seen_req = 1'b0; seen_rsp = 1'b0;
    while (!got && cyc < 60) begin
      if (resp_valid) begin
        if (!seen_rsp) begin
          seen_rsp = 1'b1;
          r_lat = cyc;
          r_rdata = resp_rdata;
          r_err = resp_err;
        end else if (resp_rdata !== r_rdata || resp_err !== r_err) begin
          r_unstable = 1'b1;
        end
        if (ps >= resp_stall) begin
          resp_ready = 1'b1;
          got = 1'b1;
        end
        ps++;
      end else if (mem_req_valid) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          r_addr = mem_req_addr; r_wen = mem_req_wen;
          r_mask = mem_req_wmask; r_wdata = mem_req_wdata;
        end else if (mem_req_addr !== r_addr || mem_req_wen !== r_wen ||
                     mem_req_wmask !== r_mask || mem_req_wdata !== r_wdata) begin
          r_unstable = 1'b1;
        end
        if (rs >= req_stall) begin
          mem_req_ready = 1'b1;
          pend = 1'b1;
          r_nreq++;
        end
        rs++;
      end
      @(negedge clk);
      cyc++;
      mem_req_ready = 1'b0;
      resp_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (pend) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rword;
        mem_rsp_err = rerr;
        pend = 1'b0;
      end
    end
    mem_rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err got %0b want 0", resp_err); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_req_valid got %0b want 0", mem_req_valid); end
    tests++; if (mem_req_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %0b want 0", mem_req_wen); end
    tests++; if (mem_req_wmask !== 4'h0) begin fails++; $display("FAIL reset_wmask got %b want 0000", mem_req_wmask); end
    tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h want 0", mem_req_addr); end
    tests++; if (mem_req_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", mem_req_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    run(1'b0, 3'b000, 32'h8000_0003, '0, 32'h80FF_1234, 1'b0, 0, 0);
    tests++; if (r_rdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata got %h want ffffff80", r_rdata); end
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL lb_err got %0b want 0", r_err); end
    tests++; if (r_lat !== 3) begin fails++; $display("FAIL lb_latency got %0d want 3", r_lat); end
    tests++; if (r_addr !== 32'h8000_0000) begin fails++; $display("FAIL lb_addr got %h want 80000000", r_addr); end
    tests++; if (r_wen !== 1'b0) begin fails++; $display("FAIL lb_wen got %0b want 0", r_wen); end
    tests++; if (r_nreq !== 1) begin fails++; $display("FAIL lb_nreq got %0d want 1", r_nreq); end
    run(1'b0, 3'b100, 32'h8000_0003, '0, 32'h80FF_1234, 1'b0, 0, 0);
    tests++; if (r_rdata !== 32'h0000_0080) begin fails++; $display("FAIL lbu_rdata got %h want 00000080", r_rdata); end
    run(1'b0, 3'b101, 32'h8000_0002, '0, 32'h80FF_1234, 1'b0, 0, 0);
    tests++; if (r_rdata !== 32'h0000_80FF) begin fails++; $display("FAIL lhu_rdata got %h want 000080ff", r_rdata); end
    run(1'b0, 3'b001, 32'h8000_0002, '0, 32'h80FF_1234, 1'b0, 0, 0);
    tests++; if (r_rdata !== 32'hFFFF_80FF) begin fails++; $display("FAIL lh_rdata got %h want ffff80ff", r_rdata); end
    run(1'b0, 3'b000, 32'h8000_0001, '0, 32'h80FF_1234, 1'b0, 0, 0);
    tests++; if (r_rdata !== 32'h0000_0012) begin fails++; $display("FAIL lb1_rdata got %h want 00000012", r_rdata); end
  endtask

  task automatic test_stores();
    run(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 0);
    tests++; if (r_mask !== 4'b1100) begin fails++; $display("FAIL sh_mask got %b want 1100", r_mask); end
    tests++; if (r_wdata !== 32'hBEEF_BEEF) begin fails++; $display("FAIL sh_wdata got %h want beefbeef", r_wdata); end
    tests++; if (r_addr !== 32'h8000_0000) begin fails++; $display("FAIL sh_addr got %h want 80000000", r_addr); end
    tests++; if (r_wen !== 1'b1) begin fails++; $display("FAIL sh_wen got %0b want 1", r_wen); end
    tests++; if (r_rdata !== 32'h0) begin fails++; $display("FAIL sh_rdata got %h want 0", r_rdata); end
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL sh_err got %0b want 0", r_err); end
    run(1'b1, 3'b000, 32'h0000_1005, 32'h1234_56A7, '0, 1'b0, 0, 0);
    tests++; if (r_mask !== 4'b0010) begin fails++; $display("FAIL sb_mask got %b want 0010", r_mask); end
    tests++; if (r_wdata !== 32'hA7A7_A7A7) begin fails++; $display("FAIL sb_wdata got %h want a7a7a7a7", r_wdata); end
    tests++; if (r_addr !== 32'h0000_1004) begin fails++; $display("FAIL sb_addr got %h want 00001004", r_addr); end
    run(1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, '0, 1'b0, 0, 0);
    tests++; if (r_mask !== 4'b1111) begin fails++; $display("FAIL sw_mask got %b want 1111", r_mask); end
    tests++; if (r_wdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL sw_wdata got %h want cafef00d", r_wdata); end
  endtask

  task automatic test_errors();
    run(1'b0, 3'b010, 32'h8000_0001, '0, '0, 1'b0, 0, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL lw_mis_err got %0b want 1", r_err); end
    tests++; if (r_lat !== 1) begin fails++; $display("FAIL lw_mis_latency got %0d want 1", r_lat); end
    tests++; if (r_nreq !== 0) begin fails++; $display("FAIL lw_mis_nreq got %0d want 0", r_nreq); end
    tests++; if (r_rdata !== 32'h0) begin fails++; $display("FAIL lw_mis_rdata got %h want 0", r_rdata); end
    run(1'b1, 3'b011, 32'h8000_0000, 32'h1111_1111, '0, 1'b0, 0, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL st_op011_err got %0b want 1", r_err); end
    tests++; if (r_nreq !== 0) begin fails++; $display("FAIL st_op011_nreq got %0d want 0", r_nreq); end
    run(1'b1, 3'b100, 32'h8000_0000, 32'h1111_1111, '0, 1'b0, 0, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL st_op100_err got %0b want 1", r_err); end
    run(1'b0, 3'b101, 32'h8000_0003, '0, '0, 1'b0, 0, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL lhu_mis_err got %0b want 1", r_err); end
    run(1'b0, 3'b110, 32'h8000_0000, '0, '0, 1'b0, 0, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL ld_op110_err got %0b want 1", r_err); end
  endtask

  task automatic test_stalls();
    run(1'b1, 3'b000, 32'h8000_0003, 32'h0000_005A, '0, 1'b0, 3, 2);
    tests++; if (r_unstable !== 1'b0) begin fails++; $display("FAIL stall_st_stable got %0b want 0", r_unstable); end
    tests++; if (r_nreq !== 1) begin fails++; $display("FAIL stall_st_nreq got %0d want 1", r_nreq); end
    tests++; if (r_mask !== 4'b1000) begin fails++; $display("FAIL stall_st_mask got %b want 1000", r_mask); end
    run(1'b0, 3'b010, 32'h8000_0004, '0, 32'h0BAD_CAFE, 1'b0, 3, 2);
    tests++; if (r_unstable !== 1'b0) begin fails++; $display("FAIL stall_ld_stable got %0b want 0", r_unstable); end
    tests++; if (r_nreq !== 1) begin fails++; $display("FAIL stall_ld_nreq got %0d want 1", r_nreq); end
    tests++; if (r_rdata !== 32'h0BAD_CAFE) begin fails++; $display("FAIL stall_ld_rdata got %h want 0badcafe", r_rdata); end
    tests++; if (r_lat !== 6) begin fails++; $display("FAIL stall_ld_latency got %0d want 6", r_lat); end
  endtask

  task automatic test_bus_err();
    run(1'b0, 3'b001, 32'h8000_0002, '0, 32'h7777_7777, 1'b1, 0, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL buserr_err got %0b want 1", r_err); end
    tests++; if (r_rdata !== 32'h0) begin fails++; $display("FAIL buserr_rdata got %h want 0", r_rdata); end
    tests++; if (r_nreq !== 1) begin fails++; $display("FAIL buserr_nreq got %0d want 1", r_nreq); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_op = 3'b010;
    req_addr = 32'h8000_0010;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_req_ready got %0b want 1", req_ready); end
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL midrst_mem_req_valid got %0b want 0", mem_req_valid); end
    tests++; if (mem_req_addr !== 32'h0) begin fails++; $display("FAIL midrst_addr got %h want 0", mem_req_addr); end
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL midrst_late_rsp got %0b want 0", resp_valid); end
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midrst_idle got %0b want 1", req_ready); end
    run(1'b0, 3'b010, 32'h8000_0020, '0, 32'h1122_3344, 1'b0, 0, 0);
    tests++; if (r_rdata !== 32'h1122_3344) begin fails++; $display("FAIL midrst_lw_rdata got %h want 11223344", r_rdata); end
    tests++; if (r_lat !== 3) begin fails++; $display("FAIL midrst_lw_latency got %0d want 3", r_lat); end
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL midrst_lw_err got %0b want 0", r_err); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_stalls();
    test_bus_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
